// File: rtl/spi_ctrl_pkg.sv
// Shared definitions for the SPI requester arbiter/sequencer.
// Holds the FSM state encoding, the default timing parameters, the
// payload widths and the two-way round-robin pick helper.
package spi_ctrl_pkg;

    localparam int unsigned CS_SETUP_DEF = 4;
    localparam int unsigned CS_HOLD_DEF  = 4;
    localparam int unsigned TIMEOUT_DEF  = 64;

    localparam int unsigned NUM_REQ = 2;
    localparam int unsigned BYTE_W  = 8;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_SETUP      = 3'd1,
        ST_LOAD       = 3'd2,
        ST_START_WAIT = 3'd3,
        ST_BUSY_WAIT  = 3'd4,
        ST_CAPTURE    = 3'd5,
        ST_HOLD       = 3'd6
    } state_e;

    // One-hot winner among two requesters; prio=1 lets requester 1 win a tie.
    function automatic logic [NUM_REQ-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                                   input logic               prio);
        logic [NUM_REQ-1:0] pick;
        pick = req;
        if (req == 2'b11) begin
            pick = prio ? 2'b10 : 2'b01;
        end
        return pick;
    endfunction

endpackage

// File: rtl/spi_rr_arbiter.sv
// Two-requester round-robin arbiter.
// Ports:
//   clk    - clock
//   req    - request vector
//   update - commit the current grant; the other requester wins the next tie
//   clear  - synchronous clear, requester 0 wins the next tie
//   grant  - combinational one-hot winner, 0 when nothing is requested
module spi_rr_arbiter
    import spi_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic [NUM_REQ-1:0] req,
    input  logic               update,
    input  logic               clear,
    output logic [NUM_REQ-1:0] grant
);

    // 1: requester 1 has tie priority
    logic prio_q;

    always_comb begin
        grant = rr_pick(req, prio_q);
    end

    // After serving requester 0 the tie goes to requester 1, and vice versa.
    always_ff @(posedge clk) begin
        if (clear) begin
            prio_q <= 1'b0;
        end else if (update) begin
            prio_q <= grant[0];
        end
    end

endmodule

// File: rtl/spi_arbiter_seq.sv
// Arbitrates two requesters onto one SPI core and sequences each
// transaction: chip-select setup, per-byte load/start/wait/capture,
// chip-select hold. A start that the core never acknowledges is aborted
// after TIMEOUT cycles with an error pulse.
// Ports:
//   raw_clk, reset         - clock, synchronous active-high reset
//   req, last              - per-requester request and final-byte flag
//   tx_data0, tx_data1     - byte offered by each requester
//   tx_ack, rx_valid       - per-requester one-cycle pulses
//   rx_data                - captured byte (shared)
//   grant, cs_n, error     - owner, chip selects, timeout pulse
//   spi_start, spi_data_in - command to the SPI core
//   spi_data_out, spi_busy - status/data from the SPI core
module spi_arbiter_seq
    import spi_ctrl_pkg::*;
#(
    parameter int unsigned CS_SETUP = CS_SETUP_DEF,
    parameter int unsigned CS_HOLD  = CS_HOLD_DEF,
    parameter int unsigned TIMEOUT  = TIMEOUT_DEF
) (
    input  logic               raw_clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] last,
    input  logic [BYTE_W-1:0]  tx_data0,
    input  logic [BYTE_W-1:0]  tx_data1,
    output logic [NUM_REQ-1:0] tx_ack,
    output logic [BYTE_W-1:0]  rx_data,
    output logic [NUM_REQ-1:0] rx_valid,
    output logic [NUM_REQ-1:0] grant,
    output logic               error,
    output logic [NUM_REQ-1:0] cs_n,
    output logic               spi_start,
    output logic [BYTE_W-1:0]  spi_data_in,
    input  logic [BYTE_W-1:0]  spi_data_out,
    input  logic               spi_busy
);

    // One counter serves setup, timeout and hold; sized for the largest.
    localparam int unsigned CNT_MAX =
        (CS_SETUP > CS_HOLD) ? ((CS_SETUP > TIMEOUT) ? CS_SETUP : TIMEOUT)
                             : ((CS_HOLD  > TIMEOUT) ? CS_HOLD  : TIMEOUT);
    localparam int unsigned CNT_W = $clog2(CNT_MAX + 1);

    state_e               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 last_q;

    logic [NUM_REQ-1:0]   arb_grant_c;
    logic                 arb_update_c;
    logic [BYTE_W-1:0]    tx_sel_c;
    logic                 last_sel_c;

    // Arbitration only happens in IDLE, so a request seen during HOLD waits.
    assign arb_update_c = (state_q == ST_IDLE) && (|req);

    spi_rr_arbiter u_arb (
        .clk    (raw_clk),
        .req    (req),
        .update (arb_update_c),
        .clear  (reset),
        .grant  (arb_grant_c)
    );

    // Byte and last flag of the current owner.
    assign tx_sel_c   = grant[1] ? tx_data1 : tx_data0;
    assign last_sel_c = |(last & grant);

    // Sequencer with registered outputs.
    always_ff @(posedge raw_clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            last_q      <= 1'b0;
            cs_n        <= 2'b11;
            grant       <= 2'b00;
            spi_start   <= 1'b0;
            spi_data_in <= '0;
            rx_data     <= '0;
            tx_ack      <= 2'b00;
            rx_valid    <= 2'b00;
            error       <= 1'b0;
        end else begin
            tx_ack   <= 2'b00;
            rx_valid <= 2'b00;
            error    <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (|req) begin
                        grant   <= arb_grant_c;
                        cs_n    <= ~arb_grant_c;
                        cnt_q   <= '0;
                        state_q <= ST_SETUP;
                    end
                end

                ST_SETUP: begin
                    if (cnt_q == CNT_W'(CS_SETUP - 1)) begin
                        cnt_q   <= '0;
                        state_q <= ST_LOAD;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                ST_LOAD: begin
                    spi_data_in <= tx_sel_c;
                    last_q      <= last_sel_c;
                    tx_ack      <= grant;
                    spi_start   <= 1'b1;
                    cnt_q       <= '0;
                    state_q     <= ST_START_WAIT;
                end

                ST_START_WAIT: begin
                    if (spi_busy) begin
                        spi_start <= 1'b0;
                        state_q   <= ST_BUSY_WAIT;
                    end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        // Core never answered: abort to HOLD without a capture.
                        spi_start <= 1'b0;
                        error     <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= ST_HOLD;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                ST_BUSY_WAIT: begin
                    if (!spi_busy) begin
                        state_q <= ST_CAPTURE;
                    end
                end

                ST_CAPTURE: begin
                    rx_data  <= spi_data_out;
                    rx_valid <= grant;
                    cnt_q    <= '0;
                    state_q  <= last_q ? ST_HOLD : ST_LOAD;
                end

                ST_HOLD: begin
                    if (cnt_q == CNT_W'(CS_HOLD - 1)) begin
                        cs_n    <= 2'b11;
                        grant   <= 2'b00;
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                default: begin
                    cs_n      <= 2'b11;
                    grant     <= 2'b00;
                    spi_start <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_arbiter_seq.sv
// Directed bench for spi_arbiter_seq with a behavioural SPI core:
// busy rises 16 cycles after start, stays high 256 cycles, and
// data_out = data_in ^ 8'hFF.
module tb_spi_arbiter_seq;

    logic       raw_clk;
    logic       reset;
    logic [1:0] req;
    logic [1:0] last;
    logic [7:0] tx_data0;
    logic [7:0] tx_data1;
    logic [1:0] tx_ack;
    logic [7:0] rx_data;
    logic [1:0] rx_valid;
    logic [1:0] grant;
    logic       error;
    logic [1:0] cs_n;
    logic       spi_start;
    logic [7:0] spi_data_in;
    logic [7:0] spi_data_out;
    logic       spi_busy;

    logic       stuck;

    int errors = 0;
    int checks = 0;

    spi_arbiter_seq dut (
        .raw_clk      (raw_clk),
        .reset        (reset),
        .req          (req),
        .last         (last),
        .tx_data0     (tx_data0),
        .tx_data1     (tx_data1),
        .tx_ack       (tx_ack),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .grant        (grant),
        .error        (error),
        .cs_n         (cs_n),
        .spi_start    (spi_start),
        .spi_data_in  (spi_data_in),
        .spi_data_out (spi_data_out),
        .spi_busy     (spi_busy)
    );

    initial raw_clk = 1'b0;
    always #5 raw_clk = ~raw_clk;

    // Behavioural SPI core; 'stuck' makes it ignore start entirely.
    logic [1:0] m_phase;
    logic [8:0] m_cnt;
    always @(posedge raw_clk) begin
        if (reset) begin
            m_phase      <= 2'd0;
            m_cnt        <= 9'd0;
            spi_busy     <= 1'b0;
            spi_data_out <= 8'h00;
        end else begin
            case (m_phase)
                2'd0: if (spi_start && !stuck) begin
                    m_phase      <= 2'd1;
                    m_cnt        <= 9'd1;
                    spi_data_out <= spi_data_in ^ 8'hFF;
                end
                2'd1: if (m_cnt == 9'd16) begin
                    spi_busy <= 1'b1;
                    m_phase  <= 2'd2;
                    m_cnt    <= 9'd1;
                end else begin
                    m_cnt <= m_cnt + 9'd1;
                end
                default: if (m_cnt == 9'd256) begin
                    spi_busy <= 1'b0;
                    m_phase  <= 2'd0;
                end else begin
                    m_cnt <= m_cnt + 9'd1;
                end
            endcase
        end
    end

    // Event counters and safety flags, sampled away from the active edge.
    int         n_ack0 = 0, n_ack1 = 0, n_rx0 = 0, n_rx1 = 0, n_err = 0;
    int         cs_falls = 0, cs1_rises = 0;
    int         both_low = 0, cs_nogrant = 0;
    logic [1:0] prev_cs = 2'b11;
    always @(negedge raw_clk) begin
        if (tx_ack[0])   n_ack0++;
        if (tx_ack[1])   n_ack1++;
        if (rx_valid[0]) n_rx0++;
        if (rx_valid[1]) n_rx1++;
        if (error === 1'b1) n_err++;
        if (cs_n === 2'b00) both_low++;
        if (cs_n !== 2'b11 && grant === 2'b00) cs_nogrant++;
        if (prev_cs === 2'b11 && cs_n !== 2'b11) cs_falls++;
        if (prev_cs[1] === 1'b0 && cs_n[1] === 1'b1) cs1_rises++;
        prev_cs = cs_n;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic probe(input int sel);
        case (sel)
            0:       return tx_ack[0];
            1:       return tx_ack[1];
            2:       return rx_valid[0];
            3:       return rx_valid[1];
            4:       return cs_n == 2'b11;
            5:       return cs_n != 2'b11;
            6:       return spi_start;
            7:       return error;
            8:       return spi_busy;
            default: return |rx_valid;
        endcase
    endfunction

    // Advance at least one cycle, stop at the first negedge where probe(sel) holds.
    task automatic wait_until(input string tag, input int sel, input int limit, output int cycles);
        int n;
        n = 0;
        do begin
            @(negedge raw_clk);
            n++;
        end while (!probe(sel) && n < limit);
        cycles = n;
        check(tag, 32'(probe(sel)), 32'h1);
    endtask

    initial begin
        int n;
        int s_ack1, s_rx0, s_rx1, s_r1, s_err, s_falls;
        logic [1:0] exp_own;
        logic [7:0] exp_dat;

        reset = 1'b1; req = 2'b00; last = 2'b00;
        tx_data0 = 8'h00; tx_data1 = 8'h00; stuck = 1'b0;

        // Reset state
        repeat (3) @(negedge raw_clk);
        check("rst_cs_n",        32'(cs_n),        32'h3);
        check("rst_grant",       32'(grant),       32'h0);
        check("rst_spi_start",   32'(spi_start),   32'h0);
        check("rst_spi_data_in", 32'(spi_data_in), 32'h0);
        check("rst_rx_data",     32'(rx_data),     32'h0);
        check("rst_tx_ack",      32'(tx_ack),      32'h0);
        check("rst_rx_valid",    32'(rx_valid),    32'h0);
        check("rst_error",       32'(error),       32'h0);

        // Single byte on requester 0
        req = 2'b01; last = 2'b01; tx_data0 = 8'hA5; reset = 1'b0;
        wait_until("t1_cs_assert", 5, 10, n);
        check("t1_cs_n", 32'(cs_n),  32'h2);
        check("t1_grant", 32'(grant), 32'h1);
        wait_until("t1_rx_valid", 2, 1000, n);
        check("t1_rx_data", 32'(rx_data), 32'h5A);
        wait_until("t1_cs_release", 4, 20, n);
        check("t1_hold_cycles", 32'(n), 32'd4);
        check("t1_grant_clear", 32'(grant), 32'h0);
        req = 2'b00;
        @(negedge raw_clk); #1;
        check("t1_ack0_count", 32'(n_ack0), 32'd1);
        check("t1_rx0_count",  32'(n_rx0),  32'd1);
        check("t1_rx1_count",  32'(n_rx1),  32'd0);

        // Multi-byte on requester 1; req dropped mid-transaction must not abort
        s_ack1 = n_ack1; s_rx1 = n_rx1; s_r1 = cs1_rises;
        tx_data1 = 8'h01; last = 2'b00; req = 2'b10;
        wait_until("t2_ack_b0", 1, 50, n);
        check("t2_grant", 32'(grant), 32'h2);
        tx_data1 = 8'h02; req = 2'b00;
        wait_until("t2_rxv_b0", 3, 1000, n);
        check("t2_rx_b0", 32'(rx_data), 32'hFE);
        wait_until("t2_ack_b1", 1, 50, n);
        tx_data1 = 8'h03; last = 2'b10;
        wait_until("t2_rxv_b1", 3, 1000, n);
        check("t2_rx_b1", 32'(rx_data), 32'hFD);
        wait_until("t2_ack_b2", 1, 50, n);
        wait_until("t2_rxv_b2", 3, 1000, n);
        check("t2_rx_b2", 32'(rx_data), 32'hFC);
        check("t2_cs_low_at_end", 32'(cs_n), 32'h1);
        wait_until("t2_cs_release", 4, 20, n);
        check("t2_hold_cycles", 32'(n), 32'd4);
        last = 2'b00;
        @(negedge raw_clk); #1;
        check("t2_ack1_count",  32'(n_ack1 - s_ack1),   32'd3);
        check("t2_rx1_count",   32'(n_rx1 - s_rx1),     32'd3);
        check("t2_cs1_rises",   32'(cs1_rises - s_r1),  32'd1);

        // Contention right after reset: 0, 1, 0
        reset = 1'b1;
        repeat (2) @(negedge raw_clk); #1;
        s_falls = cs_falls;
        req = 2'b11; last = 2'b11; tx_data0 = 8'h11; tx_data1 = 8'h22; reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            exp_own = (k == 1) ? 2'b10 : 2'b01;
            exp_dat = (k == 1) ? 8'hDD : 8'hEE;
            wait_until("t3_rx_valid", 9, 1500, n);
            check("t3_owner", 32'(rx_valid), 32'(exp_own));
            check("t3_rx_data", 32'(rx_data), 32'(exp_dat));
        end
        req = 2'b00;
        wait_until("t3_cs_release", 4, 20, n);
        @(negedge raw_clk); #1;
        check("t3_transactions", 32'(cs_falls - s_falls), 32'd3);
        last = 2'b00;

        // Timeout: core never raises busy
        s_rx0 = n_rx0; s_err = n_err;
        stuck = 1'b1; req = 2'b01; last = 2'b01; tx_data0 = 8'h3C;
        wait_until("t4_start", 6, 50, n);
        wait_until("t4_error", 7, 200, n);
        check("t4_timeout_cycles", 32'(n), 32'd64);
        check("t4_start_dropped", 32'(spi_start), 32'h0);
        check("t4_no_rx_valid", 32'(rx_valid), 32'h0);
        wait_until("t4_cs_release", 4, 20, n);
        check("t4_hold_cycles", 32'(n), 32'd4);
        check("t4_grant_clear", 32'(grant), 32'h0);
        req = 2'b00; stuck = 1'b0; last = 2'b00;
        @(negedge raw_clk); #1;
        check("t4_error_count", 32'(n_err - s_err), 32'd1);
        check("t4_rx0_count",   32'(n_rx0 - s_rx0), 32'd0);

        // Reset during BUSY_WAIT
        req = 2'b10; last = 2'b10; tx_data1 = 8'h77;
        wait_until("t5_busy", 8, 100, n);
        repeat (5) @(negedge raw_clk);
        check("t5_cs_before", 32'(cs_n), 32'h1);
        reset = 1'b1;
        @(negedge raw_clk);
        check("t5_cs_n",      32'(cs_n),      32'h3);
        check("t5_grant",     32'(grant),     32'h0);
        check("t5_spi_start", 32'(spi_start), 32'h0);
        check("t5_rx_valid",  32'(rx_valid),  32'h0);
        reset = 1'b0; req = 2'b00; last = 2'b00;
        repeat (3) @(negedge raw_clk); #1;

        check("never_both_cs_low", 32'(both_low),   32'd0);
        check("cs_only_with_grant", 32'(cs_nogrant), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_arbiter_seq.md
SPI_ARBITER_SEQ -- requirements
Module: spi_arbiter_seq

Interface
REQ-001 SHALL have parameter CS_SETUP, default 4, raw_clk cycles from cs_n assert to first spi_start.
REQ-002 SHALL have parameter CS_HOLD, default 4, raw_clk cycles from last byte capture to cs_n deassert.
REQ-003 SHALL have parameter TIMEOUT, default 64, max raw_clk cycles in START_WAIT before abort.
REQ-004 SHALL have one clock and a synchronous, active-high reset: clock `raw_clk`, reset `reset`.
REQ-005 Ports:
- raw_clk  in  1  clock
- reset  in  1  sync active-high reset
- req[1:0]  in  2  requester i wants the bus, held for the whole transaction
- last[1:0]  in  2  tx byte offered by requester i is its final byte
- tx_data0, tx_data1  in  8 each  byte offered by requester 0 and 1
- tx_ack[1:0]  out  2  one-cycle pulse: byte of requester i accepted
- rx_data  out  8  received byte, shared by both requesters
- rx_valid[1:0]  out  2  one-cycle pulse: rx_data valid for requester i
- grant[1:0]  out  2  one-hot owner, or 0
- error  out  1  one-cycle pulse on timeout abort
- cs_n[1:0]  out  2  active-low chip select, device i tied to requester i
- spi_start  out  1  to SPI core
- spi_data_in  out  8  to SPI core
- spi_data_out  in  8  from SPI core
- spi_busy  in  1  from SPI core, which runs on raw_clk/16

Function
REQ-006 States SHALL be IDLE, SETUP, LOAD, START_WAIT, BUSY_WAIT, CAPTURE, HOLD.
REQ-007 IDLE: on any req bit, SHALL arbitrate round-robin (requester not granted last wins a tie; requester 0 wins after reset), set grant, drive cs_n[i] low, then go to SETUP.
REQ-008 SETUP SHALL count CS_SETUP cycles, then go to LOAD.
REQ-009 LOAD SHALL latch tx_data[i] into spi_data_in and last[i] into a flag, pulse tx_ack[i] for exactly one cycle, then go to START_WAIT.
REQ-010 START_WAIT SHALL hold spi_start high until spi_busy=1 is sampled, then drop spi_start and go to BUSY_WAIT.
REQ-011 BUSY_WAIT SHALL wait for spi_busy=0, then go to CAPTURE.
REQ-012 CAPTURE SHALL register spi_data_out into rx_data and pulse rx_valid[i] for one cycle.
- If the last flag is set: go to HOLD.
- Else: go to LOAD.
REQ-013 HOLD SHALL count CS_HOLD cycles, then deassert cs_n[i], clear grant, and return to IDLE; rx_data holds its value until the next capture.
REQ-014 Dropping req[i] mid-transaction SHALL NOT abort it; only last ends a transaction.
REQ-015 If START_WAIT exceeds TIMEOUT cycles without spi_busy:
- SHALL pulse error.
- SHALL drop spi_start.
- SHALL go to HOLD, with no rx_valid pulse.
REQ-016 At most one cs_n bit SHALL be low at any time, and only while grant is nonzero.
REQ-017 Counters SHALL be sized for their parameter value and SHALL NOT wrap during a count.
REQ-018 A request arriving during HOLD SHALL be arbitrated only after the return to IDLE, so there is at least one IDLE cycle between transactions.

Reset
REQ-019 On reset, the block SHALL:
- set state IDLE;
- set cs_n=2'b11, grant=0, spi_start=0, spi_data_in=0, rx_data=0;
- clear tx_ack, rx_valid, error;
- set the round-robin pointer to favour requester 0.
REQ-020 Reset mid-transaction SHALL take effect on the next raw_clk edge with no CS_HOLD delay.

Structure
REQ-021 A shared package spi_ctrl_pkg SHALL hold the state encoding and the default CS_SETUP, CS_HOLD and TIMEOUT values.
REQ-022 The round-robin grant logic SHALL be a separate sub-module, spi_rr_arbiter, with inputs req[1:0], update and clear, and output grant[1:0].

Verification
REQ-023 The bench SHALL cover these directed scenarios, with a behavioural SPI model (busy rises 16 cycles after start and lasts 256 cycles, data_out = data_in XOR 8'hFF):
- Single byte: req0 with last=1, tx_data0=8'hA5 -> cs_n=2'b10, one tx_ack0, one rx_valid0 with rx_data=8'h5A, cs_n=2'b11 after CS_HOLD cycles.
- Multi-byte: req1 with bytes 8'h01, 8'h02, 8'h03 (last on the third) -> three rx_valid1 pulses with 8'hFE, 8'hFD, 8'hFC, and cs_n[1] low continuously.
- Contention: req=2'b11 held after reset -> requester 0 first, then requester 1, then requester 0; never both cs_n bits low.
- Timeout: spi_busy stuck at 0 -> error pulse after 64 cycles in START_WAIT, no rx_valid, block returns to IDLE.
- Reset mid-transfer: assert reset during BUSY_WAIT -> next cycle cs_n=2'b11, grant=0, spi_start=0.
